// File: rtl/drop32_mem_arb.sv
// Single-port memory arbiter for drop32: shares one bus between instruction fetch
// and data load/store, with stores posted through a small FIFO write buffer.
module drop32_mem_arb #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned SB_DEPTH    = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [XLEN-1:0]        i_pc,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic                   o_ifValid,
   input  logic                   i_loadReq,
   input  logic                   i_storeReq,
   input  logic [XLEN-1:0]        i_dataAddr,
   input  logic [XLEN-1:0]        i_dataOut,
   output logic [XLEN-1:0]        o_dataIn,
   output logic                   o_memValid,
   output logic                   o_busReq,
   output logic                   o_busWe,
   output logic [XLEN-1:0]        o_busAddr,
   output logic [XLEN-1:0]        o_busWdata,
   input  logic [XLEN-1:0]        i_busRdata,
   input  logic                   i_busAck,
   output logic                   o_storeOvf
);

   localparam int unsigned PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
   localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

   state_t          state, state_nx;
   logic            bus_req_nx, bus_we_nx;
   logic [XLEN-1:0] bus_addr_nx, bus_wdata_nx;
   logic [XLEN-1:0] fetch_addr, fetch_addr_nx;

   logic [XLEN-1:0] sb_addr [SB_DEPTH];
   logic [XLEN-1:0] sb_data [SB_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   sb_count;
   logic            sb_empty, sb_full, sb_enq, sb_deq, sb_drop;

   assign sb_empty = (sb_count == '0);
   assign sb_full  = (sb_count == CW'(SB_DEPTH));
   assign sb_deq   = (state == STORE) && i_busAck;
   // A full buffer still accepts a store in the cycle its head retires.
   assign sb_enq   = i_storeReq && (!sb_full || sb_deq);
   assign sb_drop  = i_storeReq && sb_full && !sb_deq;

   always_ff @(posedge i_clk) begin
      if (sb_enq) begin
         sb_addr[wr_ptr] <= i_dataAddr;
         sb_data[wr_ptr] <= i_dataOut;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sb_count   <= '0;
         o_storeOvf <= 1'b0;
      end else begin
         if (sb_enq) wr_ptr <= (SB_DEPTH == 1) ? '0 : wr_ptr + PW'(1);
         if (sb_deq) rd_ptr <= (SB_DEPTH == 1) ? '0 : rd_ptr + PW'(1);
         if (sb_enq && !sb_deq)      sb_count <= sb_count + CW'(1);
         else if (!sb_enq && sb_deq) sb_count <= sb_count - CW'(1);
         if (sb_drop) o_storeOvf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_busReq   <= 1'b0;
         o_busWe    <= 1'b0;
         o_busAddr  <= '0;
         o_busWdata <= '0;
         fetch_addr <= '0;
      end else begin
         state      <= state_nx;
         o_busReq   <= bus_req_nx;
         o_busWe    <= bus_we_nx;
         o_busAddr  <= bus_addr_nx;
         o_busWdata <= bus_wdata_nx;
         fetch_addr <= fetch_addr_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      bus_req_nx    = o_busReq;
      bus_we_nx     = o_busWe;
      bus_addr_nx   = o_busAddr;
      bus_wdata_nx  = o_busWdata;
      fetch_addr_nx = fetch_addr;
      unique case (state)
         IDLE: begin
            bus_req_nx = 1'b1;
            if (!sb_empty) begin
               state_nx     = STORE;
               bus_we_nx    = 1'b1;
               bus_addr_nx  = sb_addr[rd_ptr];
               bus_wdata_nx = sb_data[rd_ptr];
            end else if (i_loadReq && !i_storeReq) begin
               // A store arriving this cycle must reach memory before the load.
               state_nx    = LOAD;
               bus_we_nx   = 1'b0;
               bus_addr_nx = i_dataAddr;
            end else begin
               state_nx      = FETCH;
               bus_we_nx     = 1'b0;
               bus_addr_nx   = i_pc;
               fetch_addr_nx = i_pc;
            end
         end
         default: begin
            if (i_busAck) begin
               state_nx   = IDLE;
               bus_req_nx = 1'b0;
            end
         end
      endcase
   end

   assign o_instr    = i_busRdata[INSTR_WIDTH-1:0];
   assign o_ifValid  = (state == FETCH) && i_busAck && (fetch_addr == i_pc);
   assign o_dataIn   = i_busRdata;
   assign o_memValid = (state == LOAD) && i_busAck && i_loadReq;

endmodule

// File: tb/tb_drop32_mem_arb.sv
// Bench for drop32_mem_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_drop32_mem_arb;

   localparam int unsigned DEPTH = 2;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_pc = '0;
   logic [31:0] o_instr;
   logic        o_ifValid;
   logic        i_loadReq = 1'b0;
   logic        i_storeReq = 1'b0;
   logic [31:0] i_dataAddr = '0;
   logic [31:0] i_dataOut = '0;
   logic [31:0] o_dataIn;
   logic        o_memValid;
   logic        o_busReq;
   logic        o_busWe;
   logic [31:0] o_busAddr;
   logic [31:0] o_busWdata;
   logic [31:0] i_busRdata = '0;
   logic        i_busAck = 1'b0;
   logic        o_storeOvf;

   always #5 i_clk = ~i_clk;

   drop32_mem_arb #(.XLEN(32), .INSTR_WIDTH(32), .SB_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .o_instr(o_instr),
      .o_ifValid(o_ifValid), .i_loadReq(i_loadReq), .i_storeReq(i_storeReq),
      .i_dataAddr(i_dataAddr), .i_dataOut(i_dataOut), .o_dataIn(o_dataIn),
      .o_memValid(o_memValid), .o_busReq(o_busReq), .o_busWe(o_busWe),
      .o_busAddr(o_busAddr), .o_busWdata(o_busWdata), .i_busRdata(i_busRdata),
      .i_busAck(i_busAck), .o_storeOvf(o_storeOvf)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one outstanding bus op plus a store queue.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } st_t;
   typedef enum int {K_FETCH, K_LOAD, K_STORE} kind_t;

   st_t         sbq[$];
   bit          m_busy = 0;
   kind_t       m_kind = K_FETCH;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   bit          m_ovf = 0;

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sbq.delete();
         m_busy = 0;
         m_ovf  = 0;
         chk1("rst_busReq", o_busReq, 1'b0);
         chk1("rst_busWe", o_busWe, 1'b0);
         chk32("rst_busAddr", o_busAddr, 32'h0);
         chk32("rst_busWdata", o_busWdata, 32'h0);
         chk1("rst_storeOvf", o_storeOvf, 1'b0);
         chk1("rst_ifValid", o_ifValid, 1'b0);
         chk1("rst_memValid", o_memValid, 1'b0);
      end else begin
         bit ack, exp_if, exp_mem;
         ack     = m_busy && i_busAck;
         exp_if  = ack && (m_kind == K_FETCH) && (m_addr == i_pc);
         exp_mem = ack && (m_kind == K_LOAD) && i_loadReq;
         chk1("m_busReq", o_busReq, m_busy);
         if (m_busy) begin
            chk1("m_busWe", o_busWe, m_kind == K_STORE);
            chk32("m_busAddr", o_busAddr, m_addr);
            if (m_kind == K_STORE) chk32("m_busWdata", o_busWdata, m_wdata);
         end
         chk1("m_ifValid", o_ifValid, exp_if);
         chk1("m_memValid", o_memValid, exp_mem);
         chk1("m_storeOvf", o_storeOvf, m_ovf);
         if (exp_if)  chk32("m_instr", o_instr, i_busRdata);
         if (exp_mem) chk32("m_dataIn", o_dataIn, i_busRdata);

         if (!m_busy) begin
            m_busy = 1;
            if (sbq.size() != 0) begin
               m_kind  = K_STORE;
               m_addr  = sbq[0].addr;
               m_wdata = sbq[0].data;
            end else if (i_loadReq && !i_storeReq) begin
               m_kind = K_LOAD;
               m_addr = i_dataAddr;
            end else begin
               m_kind = K_FETCH;
               m_addr = i_pc;
            end
         end else if (ack) begin
            m_busy = 0;
            if (m_kind == K_STORE) void'(sbq.pop_front());
         end
         if (i_storeReq) begin
            if (sbq.size() < DEPTH) sbq.push_back('{addr: i_dataAddr, data: i_dataOut});
            else m_ovf = 1;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      tick();
      i_rst_n = 1'b0;
      i_pc = '0; i_loadReq = 1'b0; i_storeReq = 1'b0; i_dataAddr = '0;
      i_dataOut = '0; i_busRdata = '0; i_busAck = 1'b0;
      smp();
      tick();
      i_rst_n = 1'b1;
   endtask

   initial begin
      // Fetch only, zero-wait bus
      do_reset();
      smp();
      chk1("t1_idle_req", o_busReq, 1'b0);
      tick(); i_busAck = 1'b1; i_busRdata = 32'h0000_0013;
      smp();
      chk1("t1_req", o_busReq, 1'b1);
      chk32("t1_addr", o_busAddr, 32'h0);
      chk1("t1_we", o_busWe, 1'b0);
      chk1("t1_ifValid", o_ifValid, 1'b1);
      chk32("t1_instr", o_instr, 32'h13);
      tick(); i_busAck = 1'b0;
      smp();
      chk1("t1_gap_req", o_busReq, 1'b0);
      chk1("t1_gap_ifValid", o_ifValid, 1'b0);
      tick(); smp();
      chk1("t1_next_req", o_busReq, 1'b1);

      // Load wins over fetch
      do_reset();
      i_loadReq = 1'b1; i_dataAddr = 32'h100;
      smp(); tick(); smp();
      chk1("t2_req", o_busReq, 1'b1);
      chk1("t2_we", o_busWe, 1'b0);
      chk32("t2_addr", o_busAddr, 32'h100);
      tick(); i_busAck = 1'b1; i_busRdata = 32'hDEAD_BEEF;
      smp();
      chk1("t2_memValid", o_memValid, 1'b1);
      chk32("t2_dataIn", o_dataIn, 32'hDEAD_BEEF);
      tick(); i_busAck = 1'b0; i_loadReq = 1'b0;
      smp();
      chk1("t2_memValid_once", o_memValid, 1'b0);

      // Store buffer overflow while the bus is stalled
      do_reset();
      smp(); tick();
      i_storeReq = 1'b1; i_dataAddr = 32'h200; i_dataOut = 32'h11;
      tick(); i_dataAddr = 32'h204; i_dataOut = 32'h22;
      tick(); i_dataAddr = 32'h208; i_dataOut = 32'h33;
      tick(); i_storeReq = 1'b0;
      smp();
      chk1("t3_ovf", o_storeOvf, 1'b1);
      chk32("t3_fetch_held", o_busAddr, 32'h0);
      tick(); i_busAck = 1'b1;
      tick(); i_busAck = 1'b0;
      smp();
      chk1("t3_idle", o_busReq, 1'b0);
      tick(); smp();
      chk1("t3_w0_we", o_busWe, 1'b1);
      chk32("t3_w0_addr", o_busAddr, 32'h200);
      chk32("t3_w0_data", o_busWdata, 32'h11);
      tick(); i_busAck = 1'b1;
      tick(); i_busAck = 1'b0;
      tick(); smp();
      chk1("t3_w1_we", o_busWe, 1'b1);
      chk32("t3_w1_addr", o_busAddr, 32'h204);
      chk32("t3_w1_data", o_busWdata, 32'h22);
      tick(); i_busAck = 1'b1;
      tick(); i_busAck = 1'b0;
      tick(); smp();
      chk1("t3_after_req", o_busReq, 1'b1);
      chk1("t3_no_third_write", o_busWe, 1'b0);
      chk1("t3_ovf_sticky", o_storeOvf, 1'b1);

      // Load after store to same address is ordered behind the write
      do_reset();
      smp(); tick();
      i_storeReq = 1'b1; i_dataAddr = 32'h300; i_dataOut = 32'h55;
      tick(); i_storeReq = 1'b0; i_loadReq = 1'b1;
      tick(); i_busAck = 1'b1;
      tick(); i_busAck = 1'b0;
      smp();
      chk1("t4_idle", o_busReq, 1'b0);
      tick(); smp();
      chk1("t4_write_first", o_busWe, 1'b1);
      chk32("t4_waddr", o_busAddr, 32'h300);
      chk32("t4_wdata", o_busWdata, 32'h55);
      tick(); i_busAck = 1'b1;
      smp();
      chk1("t4_no_early_memValid", o_memValid, 1'b0);
      tick(); i_busAck = 1'b0;
      tick(); smp();
      chk1("t4_read_we", o_busWe, 1'b0);
      chk32("t4_raddr", o_busAddr, 32'h300);
      tick(); i_busAck = 1'b1; i_busRdata = 32'hCAFE_0300;
      smp();
      chk1("t4_memValid", o_memValid, 1'b1);
      chk32("t4_dataIn", o_dataIn, 32'hCAFE_0300);
      tick(); i_busAck = 1'b0; i_loadReq = 1'b0;

      // Stale fetch after a jump
      do_reset();
      i_pc = 32'h10;
      smp(); tick(); i_pc = 32'h40;
      smp();
      chk32("t5_old_addr", o_busAddr, 32'h10);
      tick(); i_busAck = 1'b1; i_busRdata = 32'h1234_5678;
      smp();
      chk1("t5_stale_ifValid", o_ifValid, 1'b0);
      tick(); i_busAck = 1'b0;
      tick(); smp();
      chk1("t5_refetch_req", o_busReq, 1'b1);
      chk32("t5_new_addr", o_busAddr, 32'h40);

      // Reset in the middle of a load with a buffered store
      do_reset();
      i_loadReq = 1'b1; i_dataAddr = 32'h500;
      smp(); tick();
      i_storeReq = 1'b1; i_dataAddr = 32'h600; i_dataOut = 32'h77;
      smp();
      chk32("t6_load_addr", o_busAddr, 32'h500);
      tick(); i_storeReq = 1'b0; i_dataAddr = 32'h500;
      tick(); i_rst_n = 1'b0; i_busAck = 1'b1;
      smp();
      chk1("t6_req_drop", o_busReq, 1'b0);
      chk1("t6_ovf", o_storeOvf, 1'b0);
      chk1("t6_no_memValid", o_memValid, 1'b0);
      tick(); i_rst_n = 1'b1; i_loadReq = 1'b0;
      smp();
      chk1("t6_stray_ack", o_memValid, 1'b0);
      chk1("t6_stray_req", o_busReq, 1'b0);
      tick(); i_busAck = 1'b0;
      smp();
      chk1("t6_buf_empty_we", o_busWe, 1'b0);
      chk32("t6_fetch_addr", o_busAddr, 32'h0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         tick();
         i_rst_n    = (c != 2000);
         i_busAck   = ($urandom_range(0, 2) != 0);
         i_busRdata = $urandom;
         if ($urandom_range(0, 5) == 0) i_pc = 32'($urandom_range(0, 15)) << 2;
         i_storeReq = ($urandom_range(0, 4) == 0);
         i_dataAddr = $urandom;
         i_dataOut  = $urandom;
         if (!i_loadReq) i_loadReq = ($urandom_range(0, 5) == 0);
         else if ($urandom_range(0, 9) == 0) i_loadReq = 1'b0;
      end
      tick();
      smp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
